cb_wr_seq: RTL and testbench
============================

CB_WR_SEQ -- requirements
Module: cb_wr_seq

Interface
REQ-001 Parameter L, default 4: number of CB lanes; width of CB_wea.
REQ-002 Parameter SEQ_CNT_DW, default 5: width of seq_cnt_out.
REQ-003 Parameter CB_DINA_SEL_DW, default 2: width of CB_dina_sel.
REQ-004 Parameter CB_AW, default 10: width of CB_addra.
REQ-005 Parameter IDX_DW, default 6: width of req_lm_idx.
REQ-006 Parameter N_LM, default 32: number of valid landmark indices.
REQ-007 Parameter LM_BASE, default 1: CB word address of landmark 0.
REQ-008 Port clk, input, 1: the single clock; all logic on its rising edge.
REQ-009 Port sys_rst, input, 1: reset, asynchronous, active-high.
REQ-010 Port req_valid, input, 1: write request present.
REQ-011 Port req_ready, output, 1: block can accept a request.
REQ-012 Port req_mode, input, 1: 0 = robot pose (x, y, xita), 1 = landmark (lx, ly).
REQ-013 Port req_lm_idx, input, IDX_DW: landmark index; ignored when req_mode = 0.
REQ-014 Port CB_dina_sel, output, CB_DINA_SEL_DW: lane-mapper select code.
REQ-015 Port seq_cnt_out, output, SEQ_CNT_DW: element counter for the lane mapper.
REQ-016 Port CB_ena, output, 1: CB port-A enable.
REQ-017 Port CB_wea, output, L: CB port-A per-lane write enable, one-hot.
REQ-018 Port CB_addra, output, CB_AW: CB port-A word address.
REQ-019 Port done, output, 1: one-cycle pulse at request completion.
REQ-020 Port err, output, 1: qualifies done; request rejected, no writes.

Function
REQ-021 Select codes: IDLE 2'b00, XYXITA 2'b10, LXLY 2'b11.
REQ-022 Handshake: request accepted in cycle T0 when req_valid && req_ready; req_ready = 1 only in state IDLE.
REQ-023 Request inputs are captured at acceptance; later changes have no effect.
REQ-024 Element count: N = 3 for mode 0 and N = 2 for mode 1.
REQ-025 FSM states: IDLE, RUN, TAIL.
REQ-026 FSM transitions: IDLE->RUN on acceptance; RUN->TAIL after N cycles; TAIL->IDLE after 1 cycle.
REQ-027 In RUN cycle k = 1..N (cycles T0+1..T0+N): seq_cnt_out = k, CB_dina_sel = mode code.
REQ-028 Outside RUN: seq_cnt_out = 0, CB_dina_sel = IDLE.
REQ-029 Write strobes are delayed one cycle to align with the downstream lane mapper's registered data.
REQ-030 In cycles T0+2..T0+N+1: CB_ena = 1, CB_wea = one-hot bit (k-1), CB_addra = 0 for mode 0 or LM_BASE + lm_idx for mode 1.
REQ-031 When not writing: CB_ena = 0, CB_wea = 0, CB_addra holds its last value.
REQ-032 done pulses in cycle T0+N+1, coincident with the last write strobe; req_ready returns at T0+N+2.
REQ-033 Mode 1 with lm_idx >= N_LM: accept, go directly to TAIL, issue no writes, keep sel/seq at IDLE/0, pulse done and err at T0+1.
REQ-034 err = 0 whenever done = 0.
REQ-035 Address sum is computed at CB_AW width; in-range indices are guaranteed not to wrap by parameter choice.

Reset
REQ-036 sys_rst asserted asynchronously forces: IDLE, req_ready=1, sel=IDLE, seq_cnt_out=0, CB_ena=0, CB_wea=0, CB_addra=0, done=0, err=0.
REQ-037 Reset mid-request aborts immediately; no further strobes; the first request after deassertion behaves as from power-up.

Structure
REQ-038 Package cb_pkg holds the select codes, LM_BASE, the pose address (0), and the element counts 3/2; it is shared with the lane mapper.
REQ-039 The block is a single module with the one-cycle strobe delay inline; no sub-module.

Verification
REQ-040 Mode-0 request at T0: seq 1,2,3 at T0+1..3; CB_wea 0001,0010,0100 at addr 0 on T0+2..4; done at T0+4; ready at T0+5.
REQ-041 Mode-1 request with idx 5: seq 1,2, sel 2'b11; CB_wea 0001,0010 at addr 6 (LM_BASE 1 + 5); done at T0+3.
REQ-042 Mode-1 request with idx 40: no CB_ena; done=1, err=1 at T0+1; sel/seq stay 0.
REQ-043 req_valid held high continuously with alternating modes: each accepted only when ready=1; no overlapping strobes.
REQ-044 sys_rst pulsed at T0+2 of a mode-0 request: all outputs go to reset values within that cycle with no clock edge; a new request afterwards completes normally.

Source files
------------

// File: rtl/cb_pkg.sv
// Shared constants for the CB write sequencer and its lane mapper:
// select codes, CB addresses, element counts and the sequencer state type.
package cb_pkg;

    localparam logic [1:0] SEL_IDLE   = 2'b00;
    localparam logic [1:0] SEL_XYXITA = 2'b10;
    localparam logic [1:0] SEL_LXLY   = 2'b11;

    localparam int LM_BASE_DEF = 1;
    localparam int ADDR_POSE   = 0;

    localparam int N_POSE_ELEM = 3;
    localparam int N_LM_ELEM   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_TAIL = 2'd2
    } cb_state_e;

endpackage

// File: rtl/cb_wr_seq_if.sv
// Request handshake plus CB port-A / lane-mapper control bundle of the
// CB write sequencer.
interface cb_wr_seq_if #(
    parameter int L              = 4,
    parameter int SEQ_CNT_DW     = 5,
    parameter int CB_DINA_SEL_DW = 2,
    parameter int CB_AW          = 10,
    parameter int IDX_DW         = 6
);
    import cb_pkg::*;

    logic                      req_valid;
    logic                      req_ready;
    logic                      req_mode;
    logic [IDX_DW-1:0]         req_lm_idx;
    logic [CB_DINA_SEL_DW-1:0] CB_dina_sel;
    logic [SEQ_CNT_DW-1:0]     seq_cnt_out;
    logic                      CB_ena;
    logic [L-1:0]              CB_wea;
    logic [CB_AW-1:0]          CB_addra;
    logic                      done;
    logic                      err;

    modport master (
        output req_valid, req_mode, req_lm_idx,
        input  req_ready, CB_dina_sel, seq_cnt_out, CB_ena, CB_wea, CB_addra,
               done, err
    );

    modport slave (
        input  req_valid, req_mode, req_lm_idx,
        output req_ready, CB_dina_sel, seq_cnt_out, CB_ena, CB_wea, CB_addra,
               done, err
    );

endinterface

// File: rtl/cb_wr_seq.sv
// CB write sequencer: steps the lane mapper through a pose or landmark
// record and issues one-hot lane writes one cycle behind the element count.
//
// state | meaning
// IDLE  | ready for a request
// RUN   | element counter 1..N driving the lane mapper
// TAIL  | last write strobe and done pulse; ready again next cycle
module cb_wr_seq
    import cb_pkg::*;
#(
    parameter int L              = 4,
    parameter int SEQ_CNT_DW     = 5,
    parameter int CB_DINA_SEL_DW = 2,
    parameter int CB_AW          = 10,
    parameter int IDX_DW         = 6,
    parameter int N_LM           = 32,
    parameter int LM_BASE        = LM_BASE_DEF
) (
    input logic       clk,
    input logic       sys_rst,
    cb_wr_seq_if.slave bus
);

    cb_state_e                 state;
    logic                      ready;
    logic [CB_DINA_SEL_DW-1:0] sel;
    logic [SEQ_CNT_DW-1:0]     seq;
    logic                      ena;
    logic [L-1:0]              wea;
    logic [CB_AW-1:0]          addra;
    logic                      done_r;
    logic                      err_r;
    logic [SEQ_CNT_DW-1:0]     n_q;
    logic [CB_AW-1:0]          addr_q;

    logic                      lm_oob;
    logic [CB_AW-1:0]          lm_addr;

    assign lm_oob  = 32'(bus.req_lm_idx) >= N_LM;
    assign lm_addr = CB_AW'(LM_BASE) + CB_AW'(bus.req_lm_idx);

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state  <= ST_IDLE;
            ready  <= 1'b1;
            sel    <= CB_DINA_SEL_DW'(SEL_IDLE);
            seq    <= '0;
            ena    <= 1'b0;
            wea    <= '0;
            addra  <= '0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
            n_q    <= '0;
            addr_q <= '0;
        end else begin
            ena    <= 1'b0;
            wea    <= '0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        ready <= 1'b0;
                        if (bus.req_mode && lm_oob) begin
                            state  <= ST_TAIL;
                            done_r <= 1'b1;
                            err_r  <= 1'b1;
                        end else begin
                            state  <= ST_RUN;
                            seq    <= SEQ_CNT_DW'(1);
                            sel    <= bus.req_mode ? CB_DINA_SEL_DW'(SEL_LXLY)
                                                   : CB_DINA_SEL_DW'(SEL_XYXITA);
                            n_q    <= bus.req_mode ? SEQ_CNT_DW'(N_LM_ELEM)
                                                   : SEQ_CNT_DW'(N_POSE_ELEM);
                            addr_q <= bus.req_mode ? lm_addr : CB_AW'(ADDR_POSE);
                        end
                    end
                end
                ST_RUN: begin
                    // strobe for element k lands in the cycle after seq = k
                    ena   <= 1'b1;
                    wea   <= L'(1) << (seq - SEQ_CNT_DW'(1));
                    addra <= addr_q;
                    if (seq == n_q) begin
                        state  <= ST_TAIL;
                        seq    <= '0;
                        sel    <= CB_DINA_SEL_DW'(SEL_IDLE);
                        done_r <= 1'b1;
                    end else begin
                        seq <= seq + SEQ_CNT_DW'(1);
                    end
                end
                ST_TAIL: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready   = ready;
    assign bus.CB_dina_sel = sel;
    assign bus.seq_cnt_out = seq;
    assign bus.CB_ena      = ena;
    assign bus.CB_wea      = wea;
    assign bus.CB_addra    = addra;
    assign bus.done        = done_r;
    assign bus.err         = err_r;

endmodule

// File: tb/tb_cb_wr_seq.sv
// Bench for cb_wr_seq: a cycle-schedule model filled at each acceptance,
// checked every cycle, plus directed literal sequences and a reset abort.
module tb_cb_wr_seq;

    localparam int L = 4, SEQ_CNT_DW = 5, SEL_DW = 2, CB_AW = 10, IDX_DW = 6;
    localparam int N_LM = 32, LM_BASE = 1;

    typedef struct packed {
        logic [1:0] sel;
        logic [4:0] seq;
        logic       ena;
        logic [3:0] wea;
        logic [9:0] addr;
        logic       done;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic sys_rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   busy_until = 0;
    logic [9:0] last_addr = '0;
    exp_t ring [16];

    cb_wr_seq_if #(.L(L), .SEQ_CNT_DW(SEQ_CNT_DW), .CB_DINA_SEL_DW(SEL_DW),
                   .CB_AW(CB_AW), .IDX_DW(IDX_DW)) bus ();

    cb_wr_seq #(.L(L), .SEQ_CNT_DW(SEQ_CNT_DW), .CB_DINA_SEL_DW(SEL_DW),
                .CB_AW(CB_AW), .IDX_DW(IDX_DW), .N_LM(N_LM), .LM_BASE(LM_BASE))
        dut (.clk(clk), .sys_rst(sys_rst), .bus(bus));

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic flush_model();
        for (int i = 0; i < 16; i++) ring[i] = '0;
        busy_until = 0;
        last_addr  = '0;
    endtask

    // Accepted at cycle t0: lay out every output the request will produce.
    task automatic accept(input int t0, input logic mode, input int idx);
        int n;
        logic [1:0] code;
        logic [9:0] a;
        if (mode && idx >= N_LM) begin
            ring[(t0 + 1) % 16].done = 1'b1;
            ring[(t0 + 1) % 16].err  = 1'b1;
            busy_until = t0 + 2;
        end else begin
            n    = mode ? 2 : 3;
            code = mode ? 2'b11 : 2'b10;
            a    = mode ? 10'(LM_BASE + idx) : 10'd0;
            for (int k = 1; k <= n; k++) begin
                ring[(t0 + k) % 16].seq     = 5'(k);
                ring[(t0 + k) % 16].sel     = code;
                ring[(t0 + k + 1) % 16].ena  = 1'b1;
                ring[(t0 + k + 1) % 16].wea  = 4'(1 << (k - 1));
                ring[(t0 + k + 1) % 16].addr = a;
            end
            ring[(t0 + n + 1) % 16].done = 1'b1;
            busy_until = t0 + n + 2;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_sel"},   32'(bus.CB_dina_sel), 32'd0);
        chk({tag, "_seq"},   32'(bus.seq_cnt_out), 32'd0);
        chk({tag, "_ena"},   32'(bus.CB_ena), 32'd0);
        chk({tag, "_wea"},   32'(bus.CB_wea), 32'd0);
        chk({tag, "_addr"},  32'(bus.CB_addra), 32'd0);
        chk({tag, "_done"},  32'(bus.done), 32'd0);
        chk({tag, "_err"},   32'(bus.err), 32'd0);
    endtask

    initial begin
        exp_t e;
        logic exp_ready;
        logic [9:0] exp_addr;
        flush_model();
        forever begin
            @(negedge clk);
            if (sys_rst) begin
                chk_reset_vals("rst");
                flush_model();
            end else begin
                e         = ring[cyc % 16];
                exp_ready = (cyc >= busy_until);
                exp_addr  = e.ena ? e.addr : last_addr;
                chk("ready", 32'(bus.req_ready), 32'(exp_ready));
                chk("sel",   32'(bus.CB_dina_sel), 32'(e.sel));
                chk("seq",   32'(bus.seq_cnt_out), 32'(e.seq));
                chk("ena",   32'(bus.CB_ena), 32'(e.ena));
                chk("wea",   32'(bus.CB_wea), 32'(e.wea));
                chk("addr",  32'(bus.CB_addra), 32'(exp_addr));
                chk("done",  32'(bus.done), 32'(e.done));
                chk("err",   32'(bus.err), 32'(e.err));
                last_addr = exp_addr;
                ring[cyc % 16] = '0;
                if (bus.req_valid && exp_ready)
                    accept(cyc, bus.req_mode, int'(bus.req_lm_idx));
            end
        end
    end

    task automatic issue(input logic mode, input int idx);
        @(posedge clk);
        #2;
        bus.req_valid  = 1'b1;
        bus.req_mode   = mode;
        bus.req_lm_idx = 6'(idx);
        @(posedge clk);
        #2;
        bus.req_valid  = 1'b0;
        bus.req_mode   = ~mode;
        bus.req_lm_idx = 6'(idx + 7);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            bus.req_valid = 1'b0;
        end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_mode   = 1'b0;
        bus.req_lm_idx = '0;
        repeat (3) @(posedge clk);
        #2;
        sys_rst = 1'b0;
        idle(2);

        // pose: seq 1..3, lanes 0001/0010/0100 at address 0
        issue(1'b0, 0);
        @(negedge clk); chk("p_seq1", 32'(bus.seq_cnt_out), 32'd1);
                        chk("p_sel1", 32'(bus.CB_dina_sel), 32'd2);
        @(negedge clk); chk("p_wea1", 32'(bus.CB_wea), 32'h1);
                        chk("p_adr1", 32'(bus.CB_addra), 32'd0);
        @(negedge clk); chk("p_wea2", 32'(bus.CB_wea), 32'h2);
        @(negedge clk); chk("p_wea3", 32'(bus.CB_wea), 32'h4);
                        chk("p_done", 32'(bus.done), 32'd1);
                        chk("p_rdy4", 32'(bus.req_ready), 32'd0);
        @(negedge clk); chk("p_rdy5", 32'(bus.req_ready), 32'd1);
        idle(2);

        // landmark 5 -> address 6
        issue(1'b1, 5);
        @(negedge clk); chk("l_sel1", 32'(bus.CB_dina_sel), 32'd3);
        @(negedge clk); chk("l_wea1", 32'(bus.CB_wea), 32'h1);
                        chk("l_adr1", 32'(bus.CB_addra), 32'd6);
        @(negedge clk); chk("l_wea2", 32'(bus.CB_wea), 32'h2);
                        chk("l_done", 32'(bus.done), 32'd1);
        @(negedge clk); chk("l_rdy", 32'(bus.req_ready), 32'd1);
        idle(2);

        // out-of-range landmark: immediate done+err, no writes
        issue(1'b1, 40);
        @(negedge clk); chk("e_done", 32'(bus.done), 32'd1);
                        chk("e_err",  32'(bus.err), 32'd1);
                        chk("e_ena",  32'(bus.CB_ena), 32'd0);
                        chk("e_seq",  32'(bus.seq_cnt_out), 32'd0);
        @(negedge clk); chk("e_rdy", 32'(bus.req_ready), 32'd1);
                        chk("e_adr", 32'(bus.CB_addra), 32'd6);
        idle(2);

        // boundary indices
        issue(1'b1, N_LM - 1);
        idle(5);
        issue(1'b1, N_LM);
        idle(3);

        // valid held high, modes alternating every cycle
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #2;
            bus.req_valid  = 1'b1;
            bus.req_mode   = i[0];
            bus.req_lm_idx = 6'($urandom_range(0, 35));
        end
        idle(4);

        // asynchronous reset in the middle of a pose request
        issue(1'b0, 0);
        @(posedge clk);
        #2;
        chk("a_pre_ena", 32'(bus.CB_ena), 32'd1);
        #1;
        sys_rst = 1'b1;
        #1;
        chk_reset_vals("async");
        @(posedge clk);
        #2;
        sys_rst = 1'b0;
        issue(1'b0, 0);
        @(negedge clk); chk("r_seq1", 32'(bus.seq_cnt_out), 32'd1);
        @(negedge clk); chk("r_wea1", 32'(bus.CB_wea), 32'h1);
        @(negedge clk);
        @(negedge clk); chk("r_done", 32'(bus.done), 32'd1);
        idle(2);

        // random traffic, inputs wiggling while busy
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #2;
            bus.req_valid  = ($urandom_range(0, 2) != 0);
            bus.req_mode   = 1'($urandom_range(0, 1));
            bus.req_lm_idx = 6'($urandom_range(0, 40));
        end
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
